// File: rtl/transfer_sequencer.sv
// Beam transfer sequencer: latches the frequency word, arms the reference-sine
// generators, seeks booster/synchrotron phase coincidence and fires the kicker.
module transfer_sequencer #(
    parameter int ARM_DELAY = 64,
    parameter int WINDOW    = 65535,
    parameter int PHASE_TOL = 3,
    parameter int KICK_LEN  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cycleStart,
    input  logic        frReady,
    input  logic        beamReleased,
    input  logic [31:0] freq,
    input  logic        phaseBusterRef,
    input  logic        phaseSynchRef,
    output logic [31:0] freqOut,
    output logic        readyToOutput,
    output logic        kickerOn,
    output logic        busy,
    output logic        done,
    output logic        timeoutErr
);

    localparam int MAX_AW  = (ARM_DELAY > WINDOW) ? ARM_DELAY : WINDOW;
    localparam int MAX_CNT = (MAX_AW > KICK_LEN) ? MAX_AW : KICK_LEN;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [7:0] TOL = 8'(PHASE_TOL);

    typedef enum logic [2:0] {IDLE, WAIT_FREQ, ARM, SEEK, KICK} stateT;

    stateT         state;
    logic [CW-1:0] count;

    logic       busterPrev, synchPrev;
    logic       busterRise, synchRise;
    logic       busterEvt, synchEvt;
    logic [7:0] busterAge, synchAge;
    logic       coincident;
    logic       abortNow;

    assign busterRise = phaseBusterRef & ~busterPrev;
    assign synchRise  = phaseSynchRef & ~synchPrev;

    // Ages restart on the raw edge so that, when the registered event is seen,
    // the other marker's age equals the true edge separation in cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busterPrev <= 1'b0;
            synchPrev  <= 1'b0;
            busterEvt  <= 1'b0;
            synchEvt   <= 1'b0;
            busterAge  <= 8'hFF;
            synchAge   <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            busterPrev <= phaseBusterRef;
            synchPrev  <= phaseSynchRef;
            busterEvt  <= busterRise;
            synchEvt   <= synchRise;
            busterAge  <= busterRise ? 8'd0 : ((busterAge == 8'hFF) ? busterAge : busterAge + 8'd1);
            synchAge   <= synchRise  ? 8'd0 : ((synchAge == 8'hFF) ? synchAge : synchAge + 8'd1);
        end
    end

    assign coincident = (busterEvt && synchEvt)
                     || (busterEvt && (synchAge <= TOL))
                     || (synchEvt && (busterAge <= TOL));

    assign abortNow = beamReleased && (state inside {WAIT_FREQ, ARM, SEEK});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            freqOut       <= '0;
            readyToOutput <= 1'b0;
            kickerOn      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeoutErr    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abortNow) begin
                state         <= IDLE;
                readyToOutput <= 1'b0;
                busy          <= 1'b0;
                timeoutErr    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cycleStart) begin
                            state      <= WAIT_FREQ;
                            busy       <= 1'b1;
                            timeoutErr <= 1'b0;
                        end
                    end
                    WAIT_FREQ: begin
                        if (frReady) begin
                            freqOut       <= freq;
                            count         <= CW'(ARM_DELAY);
                            readyToOutput <= 1'b1;
                            state         <= ARM;
                        end
                    end
                    ARM: begin
                        if (count <= CW'(1)) begin
                            count <= CW'(WINDOW);
                            state <= SEEK;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                    SEEK: begin
                        // A coincidence in the final window cycle still kicks.
                        if (coincident) begin
                            count    <= CW'(KICK_LEN);
                            kickerOn <= 1'b1;
                            state    <= KICK;
                        end else if (count <= CW'(1)) begin
                            state         <= IDLE;
                            readyToOutput <= 1'b0;
                            busy          <= 1'b0;
                            timeoutErr    <= 1'b1;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                    KICK: begin
                        if (count <= CW'(1)) begin
                            state         <= IDLE;
                            kickerOn      <= 1'b0;
                            readyToOutput <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
